// File: rtl/fsm_chk_pkg.sv
// Shared types and output-code helpers for the FSM lockstep checker.
package fsm_chk_pkg;

    typedef enum logic [1:0] {IDLE, RST, RUN, END} state_t;

    localparam logic [2:0] OUT_ZERO   = 3'd0;
    localparam logic [2:0] OUT_DOIS   = 3'd2;
    localparam logic [2:0] OUT_TRES   = 3'd3;
    localparam logic [2:0] OUT_QUATRO = 3'd4;
    localparam logic [2:0] OUT_CINCO  = 3'd5;

    function automatic logic is_legal(input logic [2:0] code);
        case (code)
            OUT_ZERO, OUT_DOIS, OUT_TRES, OUT_QUATRO, OUT_CINCO: is_legal = 1'b1;
            default:                                             is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_vote3.sv
// Three-way majority voter over FSM output codes with per-unit deviation mask.
module fsm_vote3
    import fsm_chk_pkg::*;
(
    input  logic [2:0] code_a,
    input  logic [2:0] code_b,
    input  logic [2:0] code_c,
    output logic [2:0] voted,
    output logic [2:0] deviant
);

    logic       has_maj;
    logic [2:0] maj;

    always_comb begin
        has_maj = 1'b1;
        maj     = code_a;
        if (code_a == code_b || code_a == code_c) begin
            maj = code_a;
        end else if (code_b == code_c) begin
            maj = code_b;
        end else begin
            has_maj = 1'b0;
        end
    end

    // With no shared value every unit is suspect and the vote falls back to zero.
    always_comb begin
        if (has_maj) begin
            voted      = maj;
            deviant[0] = !is_legal(code_a) || (code_a != maj);
            deviant[1] = !is_legal(code_b) || (code_b != maj);
            deviant[2] = !is_legal(code_c) || (code_c != maj);
        end else begin
            voted   = OUT_ZERO;
            deviant = 3'b111;
        end
    end

endmodule

// File: rtl/fsm_lockstep_ctrl.sv
// Sequences reset/stimulus for three FSM implementations and captures the first lockstep deviation.
module fsm_lockstep_ctrl
    import fsm_chk_pkg::*;
#(
    parameter int PAT_LEN      = 16,
    parameter int RST_CYC      = 2,
    parameter int STOP_ON_FAIL = 1,
    localparam int SW          = $clog2(PAT_LEN + 1),
    localparam int RCW         = (RST_CYC > 1) ? $clog2(RST_CYC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [SW-1:0]      fail_step,
    output logic [2:0]         fail_mask,
    output logic [2:0]         voted,
    output logic               fsm_res_n,
    output logic               fsm_a,
    input  logic [2:0]         s_beh,
    input  logic [2:0]         s_gate,
    input  logic [2:0]         s_mem
);

    localparam logic [SW-1:0]  STEP_LAST = SW'(PAT_LEN);
    localparam logic [RCW-1:0] RCNT_LAST = RCW'(RST_CYC - 1);

    state_t             state;
    logic [PAT_LEN-1:0] pat_q;
    logic [SW-1:0]      step;
    logic [RCW-1:0]     rcnt;
    logic [2:0]         vote_c;
    logic [2:0]         dev_c;
    logic               first_fail;
    logic               last_step;

    fsm_vote3 u_vote (
        .code_a  (s_beh),
        .code_b  (s_gate),
        .code_c  (s_mem),
        .voted   (vote_c),
        .deviant (dev_c)
    );

    assign first_fail = (dev_c != 3'b000) && !fail;
    assign last_step  = (step == STEP_LAST) || ((STOP_ON_FAIL != 0) && first_fail);

    // pat_q shifts right once per step, so its LSB is always the next stimulus bit
    // and it has drained to zero by the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            step      <= '0;
            rcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_step <= '0;
            fail_mask <= 3'b000;
            voted     <= 3'b000;
            fsm_res_n <= 1'b0;
            fsm_a     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    fsm_res_n <= 1'b0;
                    fsm_a     <= 1'b0;
                    if (start) begin
                        pat_q     <= pattern;
                        fail      <= 1'b0;
                        fail_step <= '0;
                        fail_mask <= 3'b000;
                        busy      <= 1'b1;
                        rcnt      <= '0;
                        state     <= RST;
                    end
                end
                RST: begin
                    if (rcnt == RCNT_LAST) begin
                        state     <= RUN;
                        step      <= '0;
                        fsm_res_n <= 1'b1;
                        fsm_a     <= pat_q[0];
                        pat_q     <= pat_q >> 1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                RUN: begin
                    voted <= vote_c;
                    if (first_fail) begin
                        fail      <= 1'b1;
                        fail_step <= step;
                        fail_mask <= dev_c;
                    end
                    if (last_step) begin
                        state     <= END;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm_res_n <= 1'b0;
                        fsm_a     <= 1'b0;
                    end else begin
                        step  <= step + 1'b1;
                        fsm_a <= pat_q[0];
                        pat_q <= pat_q >> 1;
                    end
                end
                END: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_lockstep_ctrl.sv
// Randomized lockstep-checker bench: emulated FSMs with fault injection and a step-table reference.
module tb_fsm_lockstep_ctrl;

    localparam int PL = 16;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PL-1:0] pattern = '0;
    logic          busy, done, fail, fsm_res_n, fsm_a;
    logic [4:0]    fail_step;
    logic [2:0]    fail_mask, voted;
    logic [2:0]    s_beh, s_gate, s_mem;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] g_code = 3'd0;
    int         stepc  = 0;
    logic [2:0] f_en   = 3'b000;
    logic [2:0] f_val [3];
    int         f_step = 0;

    always #5 clk = ~clk;

    fsm_lockstep_ctrl #(.PAT_LEN(PL), .RST_CYC(RC), .STOP_ON_FAIL(1)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .fail(fail), .fail_step(fail_step),
        .fail_mask(fail_mask), .voted(voted), .fsm_res_n(fsm_res_n), .fsm_a(fsm_a),
        .s_beh(s_beh), .s_gate(s_gate), .s_mem(s_mem)
    );

    // Output FSM transition table: next code from (code, a).
    function automatic logic [2:0] nxt(input logic [2:0] c, input logic a);
        case (c)
            3'd0:    nxt = 3'd3;
            3'd3:    nxt = a ? 3'd5 : 3'd2;
            3'd5:    nxt = 3'd2;
            3'd2:    nxt = 3'd4;
            3'd4:    nxt = a ? 3'd3 : 3'd0;
            default: nxt = 3'd0;
        endcase
    endfunction

    // Emulated FSM units shared by all three outputs, with per-unit overrides.
    always @(posedge clk) begin
        g_code <= fsm_res_n ? nxt(g_code, fsm_a) : 3'd0;
        stepc  <= fsm_res_n ? stepc + 1 : 0;
    end
    wire inj = fsm_res_n && (stepc == f_step);
    assign s_beh  = (f_en[0] && inj) ? f_val[0] : g_code;
    assign s_gate = (f_en[1] && inj) ? f_val[1] : g_code;
    assign s_mem  = (f_en[2] && inj) ? f_val[2] : g_code;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void vote_ref(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                                     output int v, output int m);
        logic [2:0] u [3];
        int         maj;
        u[0] = a; u[1] = b; u[2] = c;
        maj = -1;
        for (int i = 0; i < 3; i++) begin
            int cnt = 0;
            for (int j = 0; j < 3; j++) if (u[j] == u[i]) cnt++;
            if (cnt >= 2) maj = int'(u[i]);
        end
        m = 0;
        if (maj < 0) begin
            v = 0;
            m = 7;
        end else begin
            v = maj;
            for (int i = 0; i < 3; i++)
                if (!(u[i] inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5}) || int'(u[i]) != maj)
                    m |= (1 << i);
        end
    endfunction

    // One full run from IDLE; spur_n >= 0 pulses start at that cycle offset (must be ignored).
    task automatic run(input logic [PL-1:0] pat, input int spur_n);
        int         exp_v [PL+1];
        int         exp_m [PL+1];
        logic [2:0] code, u0, u1, u2;
        int         last, efk, efm, ef, k;
        code = 3'd0;
        for (int s = 0; s <= PL; s++) begin
            u0 = (f_en[0] && s == f_step) ? f_val[0] : code;
            u1 = (f_en[1] && s == f_step) ? f_val[1] : code;
            u2 = (f_en[2] && s == f_step) ? f_val[2] : code;
            vote_ref(u0, u1, u2, exp_v[s], exp_m[s]);
            if (s < PL) code = nxt(code, pat[s]);
        end
        ef = 0; efk = 0; efm = 0; last = PL;
        for (int s = 0; s <= PL; s++)
            if (ef == 0 && exp_m[s] != 0) begin
                ef = 1; efk = s; efm = exp_m[s]; last = s;
            end
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        for (int n = 0; n <= RC + last + 2; n++) begin
            @(negedge clk);
            k = n - RC;
            chk("busy", int'(busy), int'(n <= RC + last));
            chk("done", int'(done), int'(n == RC + last + 1));
            chk("fsm_res_n", int'(fsm_res_n), int'(n >= RC && n <= RC + last));
            chk("fsm_a", int'(fsm_a), (k >= 0 && k <= last && k < PL) ? int'(pat[k]) : 0);
            if (n >= RC + 1 && n <= RC + last + 1)
                chk("voted", int'(voted), exp_v[n - RC - 1]);
            if (n >= RC + last + 1) begin
                chk("fail", int'(fail), ef);
                chk("fail_step", int'(fail_step), efk);
                chk("fail_mask", int'(fail_mask), efm);
            end
            start = (n == spur_n);
        end
        start = 1'b0;
    endtask

    task automatic no_fault();
        f_en = 3'b000;
    endtask

    initial begin
        logic [PL-1:0] pat;
        logic [2:0]    gc;
        int            unit;
        f_val[0] = 3'd0; f_val[1] = 3'd0; f_val[2] = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_fail_step", int'(fail_step), 0);
        chk("rst_fail_mask", int'(fail_mask), 0);
        chk("rst_voted", int'(voted), 0);
        chk("rst_res_n", int'(fsm_res_n), 0);
        chk("rst_fsm_a", int'(fsm_a), 0);
        reset = 1'b0;

        no_fault();
        run('0, -1);
        run('1, -1);

        f_en = 3'b100; f_val[2] = 3'd7; f_step = 5;
        run($urandom, -1);

        f_en = 3'b110; f_val[1] = 3'd2; f_val[2] = 3'd4; f_step = 1;
        run('0, -1);

        no_fault();
        run($urandom, RC + 4);
        run($urandom, RC + PL + 1);
        run($urandom, 0);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; pattern = PL'($urandom);
        for (int n = 0; n <= RC + 3; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_res_n", int'(fsm_res_n), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_voted", int'(voted), 0);
        chk("mid_rst_fsm_a", int'(fsm_a), 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        run($urandom, -1);

        for (int r = 0; r < 24; r++) begin
            pat = PL'($urandom);
            no_fault();
            if ($urandom_range(0, 1) == 1) begin
                f_step = $urandom_range(0, PL);
                gc = 3'd0;
                for (int s = 0; s < f_step; s++) gc = nxt(gc, pat[s]);
                unit = $urandom_range(0, 2);
                f_en = 3'b001 << unit;
                f_val[unit] = 3'($urandom_range(0, 7));
                while (f_val[unit] == gc) f_val[unit] = 3'($urandom_range(0, 7));
            end
            run(pat, ($urandom_range(0, 3) == 0) ? $urandom_range(0, RC + 6) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
